// File: rtl/augment_scheduler_pkg.sv
// Shared types and default constants for the augmentation batch scheduler.
// Holds the FSM state enum and the default batch/buffer geometry.
package augment_scheduler_pkg;

   typedef enum logic [2:0] {
      IDLE,
      KERNEL,
      LOAD,
      BLUR,
      ROT,
      NEXT,
      DONE
   } state_t;

   localparam int          DEF_NUM_IMAGES      = 16;
   localparam int          DEF_NUM_PIXELS      = 784;
   localparam logic [31:0] DEF_IMAGE_BASE_ADDR = 32'h0000_0024;
   localparam logic [10:0] DEF_BRAM_INT_BASE1  = 11'h000;
   localparam logic [10:0] DEF_BRAM_INT_BASE2  = 11'h310;
   localparam int          DEF_WDT_CYCLES      = 65535;

endpackage

// File: rtl/augment_scheduler_if.sv
// Scheduler bus: PS GPIO levels, stage start/done pulses, image pointers, status.
// master = scheduler side, slave = PS and stage-engine side.
interface augment_scheduler_if;
   import augment_scheduler_pkg::*;

   logic        start;
   logic        read_kernel;
   logic        kernel_start;
   logic        load_start;
   logic        blur_start;
   logic        rot_start;
   logic        kernel_done;
   logic        load_done;
   logic        blur_done;
   logic        rot_done;
   logic [31:0] src_addr;
   logic [10:0] bank_base;
   logic [3:0]  img_idx;
   logic        busy;
   logic        kernel_valid;
   logic        batch_done;
   logic        timeout;

   modport master (
      input  start, read_kernel,
      input  kernel_done, load_done, blur_done, rot_done,
      output kernel_start, load_start, blur_start, rot_start,
      output src_addr, bank_base, img_idx,
      output busy, kernel_valid, batch_done, timeout
   );

   modport slave (
      output start, read_kernel,
      output kernel_done, load_done, blur_done, rot_done,
      input  kernel_start, load_start, blur_start, rot_start,
      input  src_addr, bank_base, img_idx,
      input  busy, kernel_valid, batch_done, timeout
   );

endinterface

// File: rtl/augment_scheduler_stage_watchdog.sv
// Per-stage watchdog: cycles spent in the current stage, flags expiry.
// Ports: clk, reset, clr (stage start pulse), en (in a stage), expired.
module stage_watchdog #(
   parameter int WDT_CYCLES = 65535
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [31:0] cnt;

   // The start cycle is the first cycle of the stage, so restart at 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= 32'd0;
      else if (clr)
         cnt <= 32'd1;
      else if (en)
         cnt <= cnt + 32'd1;
   end

   assign expired = en & ~clr &
                    (cnt >= 32'(WDT_CYCLES - 1));

endmodule

// File: rtl/augment_scheduler.sv
// Batch scheduler: kernel load, then LOAD/BLUR/ROT per image over a batch.
// Ports: clk, reset (async, high), bus (augment_scheduler_if.master).
// Optional watchdog: define AUGMENT_SCHEDULER_WATCHDOG_EN.
module augment_scheduler
   import augment_scheduler_pkg::*;
#(
   parameter int          NUM_IMAGES      = DEF_NUM_IMAGES,
   parameter int          NUM_PIXELS      = DEF_NUM_PIXELS,
   parameter logic [31:0] IMAGE_BASE_ADDR = DEF_IMAGE_BASE_ADDR,
   parameter logic [10:0] BRAM_INT_BASE1  = DEF_BRAM_INT_BASE1,
   parameter logic [10:0] BRAM_INT_BASE2  = DEF_BRAM_INT_BASE2,
   parameter int          WDT_CYCLES      = DEF_WDT_CYCLES
) (
   input  logic                clk,
   input  logic                reset,
   augment_scheduler_if.master bus
);

   localparam logic [3:0] IDX_LAST = 4'(NUM_IMAGES - 1);

   state_t      state;
   logic        start_q, rk_q, pending;
   logic        k_st, l_st, b_st, r_st;
   logic        kv, bd;
   logic [3:0]  idx;
   logic [31:0] addr;
   logic [10:0] bank;
   logic        start_edge, rk_edge;
   logic        stage_done, wdt_fire;

   assign start_edge = bus.start & ~start_q;
   assign rk_edge    = bus.read_kernel & ~rk_q;

   // A done pulse counts only in its own stage and never in the start cycle.
   assign stage_done =
      ((state == KERNEL) & bus.kernel_done & ~k_st) |
      ((state == LOAD)   & bus.load_done   & ~l_st) |
      ((state == BLUR)   & bus.blur_done   & ~b_st) |
      ((state == ROT)    & bus.rot_done    & ~r_st);

`ifdef AUGMENT_SCHEDULER_WATCHDOG_EN
   logic wdt_expired, in_stage, timeout_q;

   assign in_stage = (state == KERNEL) | (state == LOAD) |
                     (state == BLUR) | (state == ROT);

   stage_watchdog #(
      .WDT_CYCLES (WDT_CYCLES)
   ) u_wdt (
      .clk     (clk),
      .reset   (reset),
      .clr     (k_st | l_st | b_st | r_st),
      .en      (in_stage),
      .expired (wdt_expired)
   );

   // A done arriving on the last allowed cycle still wins.
   assign wdt_fire = wdt_expired & ~stage_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         timeout_q <= 1'b0;
      else if (wdt_fire)
         timeout_q <= 1'b1;
      else if ((state == IDLE) && start_edge)
         timeout_q <= 1'b0;
   end

   assign bus.timeout = timeout_q;
`else
   localparam int unused_wdt = WDT_CYCLES;
   assign wdt_fire    = 1'b0;
   assign bus.timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         start_q <= bus.start;
         rk_q    <= bus.read_kernel;
         pending <= 1'b0;
         kv      <= 1'b0;
         bd      <= 1'b0;
         k_st    <= 1'b0;
         l_st    <= 1'b0;
         b_st    <= 1'b0;
         r_st    <= 1'b0;
         idx     <= 4'd0;
         addr    <= IMAGE_BASE_ADDR;
         bank    <= BRAM_INT_BASE1;
      end else begin
         start_q <= bus.start;
         rk_q    <= bus.read_kernel;
         k_st    <= 1'b0;
         l_st    <= 1'b0;
         b_st    <= 1'b0;
         r_st    <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start_edge) begin
                  idx  <= 4'd0;
                  addr <= IMAGE_BASE_ADDR;
                  bank <= BRAM_INT_BASE1;
                  bd   <= 1'b0;
               end
               if (rk_edge || (start_edge && !kv)) begin
                  state   <= KERNEL;
                  k_st    <= 1'b1;
                  pending <= start_edge;
               end else if (start_edge) begin
                  state <= LOAD;
                  l_st  <= 1'b1;
               end
            end
            KERNEL: begin
               if (stage_done) begin
                  kv      <= 1'b1;
                  pending <= 1'b0;
                  if (pending) begin
                     state <= LOAD;
                     l_st  <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            LOAD: begin
               if (stage_done) begin
                  state <= BLUR;
                  b_st  <= 1'b1;
               end
            end
            BLUR: begin
               if (stage_done) begin
                  state <= ROT;
                  r_st  <= 1'b1;
               end
            end
            ROT: begin
               if (stage_done)
                  state <= NEXT;
            end
            NEXT: begin
               if (idx == IDX_LAST) begin
                  state <= DONE;
                  bd    <= 1'b1;
               end else begin
                  idx   <= idx + 4'd1;
                  addr  <= addr + 32'(NUM_PIXELS);
                  bank  <= (bank == BRAM_INT_BASE1) ?
                           BRAM_INT_BASE2 : BRAM_INT_BASE1;
                  state <= LOAD;
                  l_st  <= 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
         if (wdt_fire) begin
            state   <= IDLE;
            pending <= 1'b0;
            if (state == KERNEL)
               kv <= 1'b0;
         end
      end
   end

   assign bus.kernel_start = k_st;
   assign bus.load_start   = l_st;
   assign bus.blur_start   = b_st;
   assign bus.rot_start    = r_st;
   assign bus.src_addr     = addr;
   assign bus.bank_base    = bank;
   assign bus.img_idx      = idx;
   assign bus.busy         = (state != IDLE);
   assign bus.kernel_valid = kv;
   assign bus.batch_done   = bd;

endmodule
